// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction opcodes, instruction field layout and the
// loader state encoding, used by both the instruction loader and the control unit.
package cpu_pkg;

  typedef enum logic [2:0] {
    OP_LOADI = 3'b000,
    OP_MOV   = 3'b001,
    OP_ADD   = 3'b010,
    OP_SUB   = 3'b011,
    OP_AND   = 3'b100,
    OP_OR    = 3'b101,
    OP_J     = 3'b110,
    OP_BEQ   = 3'b111
  } opcode_e;

  localparam int WORD_W   = 32;
  localparam int FIELD_W  = 8;
  localparam int OP_W     = 3;
  localparam int SRC2_LSB = 0;
  localparam int SRC1_LSB = 8;
  localparam int DEST_LSB = 16;
  localparam int OP_LSB   = 24;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_WRITE  = 2'd2,
    ST_FINISH = 2'd3
  } loader_state_e;

  // Little-endian byte select: index 0 is the least significant byte.
  function automatic logic [7:0] word_byte(input logic [WORD_W-1:0] w, input logic [1:0] idx);
    return w[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/instr_encoder.sv
// Packs instruction fields into a 32-bit word, zeroing the source fields
// that the opcode does not use.
module instr_encoder
  import cpu_pkg::*;
(
  input  logic [OP_W-1:0]    opcode,
  input  logic [FIELD_W-1:0] dest,
  input  logic [FIELD_W-1:0] src1,
  input  logic [FIELD_W-1:0] src2,
  output logic [WORD_W-1:0]  word
);

  logic [FIELD_W-1:0] src1_eff;
  logic [FIELD_W-1:0] src2_eff;

  always_comb begin
    src1_eff = src1;
    src2_eff = src2;
    case (opcode)
      OP_LOADI, OP_MOV: src1_eff = '0;
      // Jumps carry their offset in dest, so both sources are meaningless.
      OP_J: begin
        src1_eff = '0;
        src2_eff = '0;
      end
      default: ;
    endcase

    word = '0;
    word[OP_LSB   +: OP_W]    = opcode;
    word[DEST_LSB +: FIELD_W] = dest;
    word[SRC1_LSB +: FIELD_W] = src1_eff;
    word[SRC2_LSB +: FIELD_W] = src2_eff;
  end

endmodule

// File: rtl/instr_loader.sv
// Instruction loader: accepts encoded instructions over a valid/ready handshake
// and writes each one byte-by-byte into instruction memory with stall support.
module instr_loader
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              START,
  input  logic [ADDR_W-1:0] BASE_ADDR,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [2:0]        IN_OPCODE,
  input  logic [7:0]        IN_DEST,
  input  logic [7:0]        IN_SRC1,
  input  logic [7:0]        IN_SRC2,
  input  logic              IN_LAST,
  output logic              MEM_WRITE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [7:0]        MEM_WRITEDATA,
  input  logic              MEM_BUSYWAIT,
  output logic              BUSY,
  output logic              DONE,
  output logic [ADDR_W-3:0] COUNT
);

  loader_state_e     state_q, state_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        idx_q, idx_d;
  logic [ADDR_W-3:0] count_q, count_d;
  logic [WORD_W-1:0] enc_word;

  instr_encoder u_encoder (
    .opcode (IN_OPCODE),
    .dest   (IN_DEST),
    .src1   (IN_SRC1),
    .src2   (IN_SRC2),
    .word   (enc_word)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      last_q  <= 1'b0;
      addr_q  <= '0;
      idx_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    word_d        = word_q;
    last_d        = last_q;
    addr_d        = addr_q;
    idx_d         = idx_q;
    count_d       = count_q;
    IN_READY      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDR      = '0;
    MEM_WRITEDATA = '0;
    BUSY          = 1'b1;
    DONE          = 1'b0;

    case (state_q)
      ST_IDLE: begin
        BUSY = 1'b0;
        if (START) begin
          state_d = ST_ACCEPT;
          addr_d  = BASE_ADDR & ~ADDR_W'(3);
          count_d = '0;
        end
      end

      ST_ACCEPT: begin
        IN_READY = 1'b1;
        if (IN_VALID) begin
          word_d  = enc_word;
          last_d  = IN_LAST;
          idx_d   = '0;
          state_d = ST_WRITE;
        end
      end

      // Address and data come straight from held state, so they stay put while stalled.
      ST_WRITE: begin
        MEM_WRITE     = 1'b1;
        MEM_ADDR      = addr_q + ADDR_W'(idx_q);
        MEM_WRITEDATA = word_byte(word_q, idx_q);
        if (!MEM_BUSYWAIT) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            count_d = count_q + (ADDR_W-2)'(1);
            addr_d  = addr_q + ADDR_W'(4);
            state_d = last_q ? ST_FINISH : ST_ACCEPT;
          end
        end
      end

      ST_FINISH: begin
        DONE    = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign COUNT = count_q;

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: a transaction-level model predicts every
// byte write and status output, plus literal expectations for the directed sessions.
module tb_instr_loader;

  localparam int ADDR_W = 10;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } wr_t;

  logic              CLK = 1'b0;
  logic              RESET_N;
  logic              START;
  logic [ADDR_W-1:0] BASE_ADDR;
  logic              IN_VALID;
  logic              IN_READY;
  logic [2:0]        IN_OPCODE;
  logic [7:0]        IN_DEST;
  logic [7:0]        IN_SRC1;
  logic [7:0]        IN_SRC2;
  logic              IN_LAST;
  logic              MEM_WRITE;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [7:0]        MEM_WRITEDATA;
  logic              MEM_BUSYWAIT;
  logic              BUSY;
  logic              DONE;
  logic [ADDR_W-3:0] COUNT;

  logic stim_done = 1'b0;
  int   timeouts  = 0;
  int   checks    = 0;
  int   errors    = 0;

  wr_t exp_q[$];
  wr_t log_q[$];
  int  wc_log[$];
  int  done_log[$];

  wr_t exp_log [31] = '{
    '{10'h010, 8'h03}, '{10'h011, 8'h01}, '{10'h012, 8'h02}, '{10'h013, 8'h02},
    '{10'h020, 8'h7F}, '{10'h021, 8'h00}, '{10'h022, 8'h04}, '{10'h023, 8'h00},
    '{10'h024, 8'h00}, '{10'h025, 8'h00}, '{10'h026, 8'h05}, '{10'h027, 8'h06},
    '{10'h028, 8'h22}, '{10'h029, 8'h00}, '{10'h02A, 8'h07}, '{10'h02B, 8'h01},
    '{10'h3FC, 8'h03}, '{10'h3FD, 8'h02}, '{10'h3FE, 8'h01}, '{10'h3FF, 8'h03},
    '{10'h000, 8'hFF}, '{10'h001, 8'h0F}, '{10'h002, 8'hF0}, '{10'h003, 8'h05},
    '{10'h040, 8'h56}, '{10'h041, 8'h34}, '{10'h042, 8'h12},
    '{10'h080, 8'h03}, '{10'h081, 8'h02}, '{10'h082, 8'h01}, '{10'h083, 8'h07}
  };
  int exp_done [4] = '{1, 3, 2, 1};

  always #5 CLK = ~CLK;

  instr_loader #(.ADDR_W(ADDR_W)) dut (
    .CLK           (CLK),
    .RESET_N       (RESET_N),
    .START         (START),
    .BASE_ADDR     (BASE_ADDR),
    .IN_VALID      (IN_VALID),
    .IN_READY      (IN_READY),
    .IN_OPCODE     (IN_OPCODE),
    .IN_DEST       (IN_DEST),
    .IN_SRC1       (IN_SRC1),
    .IN_SRC2       (IN_SRC2),
    .IN_LAST       (IN_LAST),
    .MEM_WRITE     (MEM_WRITE),
    .MEM_ADDR      (MEM_ADDR),
    .MEM_WRITEDATA (MEM_WRITEDATA),
    .MEM_BUSYWAIT  (MEM_BUSYWAIT),
    .BUSY          (BUSY),
    .DONE          (DONE),
    .COUNT         (COUNT)
  );

  // Instruction word from the ISA rules: unused source fields read as zero.
  function automatic logic [31:0] model_word(input logic [2:0] op, input logic [7:0] d,
                                             input logic [7:0] s1, input logic [7:0] s2);
    logic [31:0] s1v;
    logic [31:0] s2v;
    s1v = 32'(s1);
    s2v = 32'(s2);
    if (op == 3'd0 || op == 3'd1) s1v = 0;
    if (op == 3'd6) begin
      s1v = 0;
      s2v = 0;
    end
    return 32'(op) * 32'h0100_0000 + 32'(d) * 32'h0001_0000 + s1v * 32'h100 + s2v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_session(input logic [ADDR_W-1:0] base);
    START     = 1'b1;
    BASE_ADDR = base;
    tick();
    START     = 1'b0;
    BASE_ADDR = 10'h155;
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [7:0] d, input logic [7:0] s1,
                               input logic [7:0] s2, input logic last);
    int n;
    IN_OPCODE = op;
    IN_DEST   = d;
    IN_SRC1   = s1;
    IN_SRC2   = s2;
    IN_LAST   = last;
    IN_VALID  = 1'b1;
    n = 0;
    while (!IN_READY && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) timeouts++;
    tick();
    IN_VALID  = 1'b0;
    IN_OPCODE = 3'd5;
    IN_DEST   = 8'hEE;
    IN_SRC1   = 8'hEE;
    IN_SRC2   = 8'hEE;
    IN_LAST   = 1'b1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (BUSY && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) timeouts++;
    tick();
  endtask

  initial begin : stimulus
    RESET_N      = 1'b0;
    START        = 1'b0;
    BASE_ADDR    = '0;
    IN_VALID     = 1'b0;
    IN_OPCODE    = '0;
    IN_DEST      = '0;
    IN_SRC1      = '0;
    IN_SRC2      = '0;
    IN_LAST      = 1'b0;
    MEM_BUSYWAIT = 1'b0;
    repeat (2) tick();
    RESET_N = 1'b1;
    tick();

    // Valid while idle must never be accepted.
    IN_VALID = 1'b1;
    repeat (3) tick();
    IN_VALID = 1'b0;
    tick();

    start_session(10'h010);
    applyStimulus(3'd2, 8'd2, 8'd1, 8'd3, 1'b1);
    wait_idle();

    // Second instruction stalls three cycles on byte 1 while a stray START is ignored.
    start_session(10'h020);
    applyStimulus(3'd0, 8'h04, 8'hAA, 8'h7F, 1'b0);
    applyStimulus(3'd6, 8'h05, 8'h09, 8'h08, 1'b0);
    tick();
    MEM_BUSYWAIT = 1'b1;
    START        = 1'b1;
    BASE_ADDR    = 10'h300;
    tick();
    START        = 1'b0;
    repeat (2) tick();
    MEM_BUSYWAIT = 1'b0;
    applyStimulus(3'd1, 8'h07, 8'h11, 8'h22, 1'b1);
    wait_idle();

    start_session(10'h3FF);
    applyStimulus(3'd3, 8'h01, 8'h02, 8'h03, 1'b0);
    applyStimulus(3'd5, 8'hF0, 8'h0F, 8'hFF, 1'b1);
    wait_idle();

    // Reset lands with byte 3 pending; the instruction is abandoned.
    start_session(10'h040);
    applyStimulus(3'd4, 8'h12, 8'h34, 8'h56, 1'b1);
    repeat (3) tick();
    RESET_N = 1'b0;
    repeat (2) tick();
    RESET_N = 1'b1;
    repeat (3) tick();

    start_session(10'h080);
    applyStimulus(3'd7, 8'h01, 8'h02, 8'h03, 1'b1);
    wait_idle();
    repeat (2) tick();
    stim_done = 1'b1;
  end

  initial begin : compare
    bit                active;
    bit                fin;
    bit                last_flag;
    bit                started;
    logic [ADDR_W-1:0] m_addr;
    logic [ADDR_W-3:0] m_count;
    int                wcyc;
    logic [31:0]       w;
    active = 0; fin = 0; last_flag = 0; started = 0;
    m_addr = '0; m_count = '0; wcyc = 0;

    while (!stim_done) begin
      @(negedge CLK);
      if (!RESET_N) begin
        checkOutput("rst_busy",  32'(BUSY), 0);
        checkOutput("rst_ready", 32'(IN_READY), 0);
        checkOutput("rst_write", 32'(MEM_WRITE), 0);
        checkOutput("rst_addr",  32'(MEM_ADDR), 0);
        checkOutput("rst_data",  32'(MEM_WRITEDATA), 0);
        checkOutput("rst_done",  32'(DONE), 0);
        checkOutput("rst_count", 32'(COUNT), 0);
        active = 0; fin = 0; started = 0; m_count = '0; wcyc = 0;
        exp_q.delete();
        continue;
      end

      checkOutput("busy",      32'(BUSY), 32'(active));
      checkOutput("in_ready",  32'(IN_READY), 32'(active && exp_q.size() == 0 && !fin));
      checkOutput("mem_write", 32'(MEM_WRITE), 32'(exp_q.size() != 0));
      checkOutput("done",      32'(DONE), 32'(fin));
      checkOutput("count",     32'(COUNT), 32'(m_count));
      if (exp_q.size() != 0) begin
        checkOutput("mem_addr", 32'(MEM_ADDR), 32'(exp_q[0].addr));
        checkOutput("mem_data", 32'(MEM_WRITEDATA), 32'(exp_q[0].data));
      end else if (!started) begin
        checkOutput("idle_addr", 32'(MEM_ADDR), 0);
        checkOutput("idle_data", 32'(MEM_WRITEDATA), 0);
      end
      if (DONE) done_log.push_back(int'(COUNT));

      if (fin) begin
        fin = 0;
        active = 0;
      end else if (!active) begin
        if (START) begin
          active  = 1;
          started = 1;
          m_addr  = BASE_ADDR & ~ADDR_W'(3);
          m_count = '0;
        end
      end else if (exp_q.size() == 0) begin
        if (IN_VALID) begin
          w = model_word(IN_OPCODE, IN_DEST, IN_SRC1, IN_SRC2);
          for (int i = 0; i < 4; i++)
            exp_q.push_back('{addr: m_addr + ADDR_W'(i), data: 8'(w >> (8 * i))});
          m_addr    = m_addr + ADDR_W'(4);
          last_flag = IN_LAST;
        end
      end else begin
        wcyc++;
        if (!MEM_BUSYWAIT) begin
          log_q.push_back('{addr: MEM_ADDR, data: MEM_WRITEDATA});
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) begin
            m_count = m_count + 1'b1;
            wc_log.push_back(wcyc);
            wcyc = 0;
            if (last_flag) fin = 1;
          end
        end
      end
    end

    checkOutput("timeouts", 32'(timeouts), 0);
    checkOutput("log_size", 32'(log_q.size()), 31);
    for (int i = 0; i < 31 && i < log_q.size(); i++)
      checkOutput($sformatf("log%0d", i), 32'(log_q[i]), 32'(exp_log[i]));
    checkOutput("done_pulses", 32'(done_log.size()), 4);
    for (int i = 0; i < 4 && i < done_log.size(); i++)
      checkOutput($sformatf("done_count%0d", i), 32'(done_log[i]), 32'(exp_done[i]));
    checkOutput("write_cycles_n", 32'(wc_log.size()), 7);
    if (wc_log.size() > 2) begin
      checkOutput("nostall_cycles", 32'(wc_log[1]), 4);
      checkOutput("stall_cycles", 32'(wc_log[2]), 7);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, giving the byte-address width of instruction memory; word count width is ADDR_W-2.
REQ-002 SHALL have port CLK  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port RESET_N  input  1  reset; it is asynchronous and active-low.
REQ-004 SHALL have port START  input  1  one-cycle request to begin a load session at BASE_ADDR.
REQ-005 SHALL have port BASE_ADDR  input  ADDR_W  first byte address; bits [1:0] ignored and treated as 0.
REQ-006 SHALL have ports IN_VALID  input  1 and IN_READY  output  1, forming the instruction-field handshake.
REQ-007 SHALL have ports IN_OPCODE  input  3, IN_DEST  input  8, IN_SRC1  input  8, IN_SRC2  input  8, IN_LAST  input  1 (final instruction of session).
REQ-008 SHALL have ports MEM_WRITE  output  1, MEM_ADDR  output  ADDR_W, MEM_WRITEDATA  output  8, MEM_BUSYWAIT  input  1 (byte-wide memory write port with stall).
REQ-009 SHALL have ports BUSY  output  1, DONE  output  1 (one-cycle pulse), COUNT  output  ADDR_W-2 (instructions written this session).

Function
REQ-010 SHALL encode word = {5'b0, opcode, dest, src1, src2}: opcode 000 loadi, 001 mov, 010 add, 011 sub, 100 and, 101 or, 110 j, 111 beq.
REQ-011 SHALL zero fields unused by the opcode: loadi zeroes src1; mov zeroes src1; j zeroes src1 and src2 (dest carries the offset); other opcodes keep all fields.
REQ-012 SHALL implement states IDLE, ACCEPT, WRITE, FINISH.
REQ-013 IDLE: START -> ACCEPT, load address from BASE_ADDR with bits [1:0] zeroed, clear COUNT; IN_VALID ignored.
REQ-014 ACCEPT: IN_READY=1; on IN_VALID&IN_READY latch encoded word and IN_LAST -> WRITE with byte index 0.
REQ-015 WRITE: MEM_WRITE=1, MEM_ADDR=word address+byte index, MEM_WRITEDATA=byte[index] little-endian (index 0 = word[7:0]).
REQ-016 WRITE: address/data SHALL hold stable while MEM_BUSYWAIT=1; a byte completes on a rising edge with MEM_WRITE=1 and MEM_BUSYWAIT=0.
REQ-017 After byte 3 completes: COUNT+1, word address+4; latched LAST -> FINISH, else -> ACCEPT.
REQ-018 FINISH: DONE=1 for exactly one cycle, then IDLE; COUNT holds until next START.
REQ-019 BUSY SHALL be 1 in ACCEPT, WRITE, FINISH; 0 in IDLE.
REQ-020 START outside IDLE SHALL be ignored.
REQ-021 Address SHALL wrap modulo 2^ADDR_W; COUNT SHALL wrap modulo 2^(ADDR_W-2); no error flagged.
REQ-022 Latency: accepted instruction with no stall -> 4 write cycles; ACCEPT->next IN_READY minimum 5 cycles.
REQ-023 IN_READY SHALL be 0 in every state but ACCEPT; fields need only be valid in the handshake cycle.

Reset
REQ-024 RESET_N=0 SHALL asynchronously force IDLE, IN_READY=0, MEM_WRITE=0, MEM_ADDR=0, MEM_WRITEDATA=0, BUSY=0, DONE=0, COUNT=0, byte index 0.
REQ-025 Reset mid-WRITE SHALL abandon the partial instruction; already-written bytes are not undone.
REQ-026 Outputs SHALL remain at reset values until the first START after RESET_N deasserts.

Structure
REQ-027 Opcode constants, field bit positions and the state encoding SHALL live in shared package cpu_pkg, shared with the control unit.
REQ-028 Field packing/zeroing (REQ-010/011) SHALL be a combinational sub-module instr_encoder; instr_loader holds the FSM, counters and latch.

Verification
REQ-029 START BASE_ADDR=0x10; send add dest=2 src1=1 src2=3 LAST=1 -> bytes 0x03,0x01,0x02,0x02 at 0x10..0x13, DONE one cycle, COUNT=1.
REQ-030 loadi dest=4 src1=0xAA src2=0x7F -> word 0x00040 07F written as 0x7F,0x00,0x04,0x00 (src1 zeroed).
REQ-031 MEM_BUSYWAIT=1 for 3 cycles on byte 1 -> MEM_ADDR/MEM_WRITEDATA constant during stall, total write time 7 cycles.
REQ-032 BASE_ADDR=0x3FC, two instructions -> second instruction at 0x000..0x003, COUNT=2.
REQ-033 RESET_N low after byte 2 -> all outputs 0 immediately, no DONE; START ignored during WRITE; IN_VALID in IDLE never accepted.
